// File: rtl/score_event_scheduler.sv
// Game-side score controller: lane hits become score credits scaled by a combo
// multiplier, metered to the external score counter one increment per clock.
//
// state | meaning
// IDLE  | score counter held in clear, waiting for start
// PLAY  | hits/misses scored, credits issued
// DRAIN | out of lives, remaining credits still issued
// OVER  | final score shown, start returns to IDLE
module score_event_scheduler #(
    parameter int LANES      = 4,
    parameter int PEND_W     = 5,
    parameter int COMBO_STEP = 8,
    parameter int MAX_MULT   = 4,
    parameter int LIVES      = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [LANES-1:0] hit,
    input  logic             miss,
    output logic             increment,
    output logic             score_resetn,
    output logic [7:0]       combo,
    output logic [2:0]       mult,
    output logic [1:0]       lives,
    output logic             busy,
    output logic             overflow,
    output logic             game_over
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN, S_OVER} state_t;

    localparam int SUM_W = PEND_W + 12;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);

    state_t            r_state, w_state_nxt;
    logic [PEND_W-1:0] r_credits, w_credits_nxt;
    logic [7:0]        r_combo, w_combo_nxt;
    logic [2:0]        r_mult, w_mult_nxt;
    logic [1:0]        r_lives, w_lives_nxt;
    logic              r_overflow, w_overflow_nxt;

    logic [7:0]        w_pop;
    logic              w_issue;
    logic [SUM_W-1:0]  w_add;
    logic [SUM_W-1:0]  w_sum;
    logic              w_clip;
    logic [8:0]        w_combo_sum;
    logic [7:0]        w_combo_hit;
    logic [8:0]        w_mult_raw;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + {7'd0, hit[i]};
        end
    end

    // Credits: every term uses pre-edge values; issue implies credits >= 1.
    always_comb begin
        w_issue = ((r_state == S_PLAY) || (r_state == S_DRAIN)) && (r_credits != '0);
        w_add   = (r_state == S_PLAY) ? (SUM_W'(w_pop) * SUM_W'(r_mult)) : '0;
        w_sum   = SUM_W'(r_credits) + w_add - SUM_W'(w_issue);
        w_clip  = (w_sum > PEND_MAX);
        w_credits_nxt = w_clip ? PEND_MAX[PEND_W-1:0] : w_sum[PEND_W-1:0];
    end

    always_comb begin
        w_combo_sum = {1'b0, r_combo} + {1'b0, w_pop};
        w_combo_hit = (w_combo_sum > 9'd255) ? 8'hFF : w_combo_sum[7:0];
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_combo_nxt    = r_combo;
        w_lives_nxt    = r_lives;
        w_overflow_nxt = r_overflow | w_clip;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_PLAY;
                    w_combo_nxt    = '0;
                    w_lives_nxt    = 2'(LIVES);
                    w_overflow_nxt = 1'b0;
                end
            end
            S_PLAY: begin
                if (miss) begin
                    w_combo_nxt = '0;
                    w_lives_nxt = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
                    if (r_lives <= 2'd1) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    w_combo_nxt = w_combo_hit;
                end
            end
            S_DRAIN: begin
                if (r_credits == '0) begin
                    w_state_nxt = S_OVER;
                end
            end
            S_OVER: begin
                if (start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Multiplier follows the updated combo so it applies from the next cycle.
    always_comb begin
        w_mult_raw = 9'd1 + ({1'b0, w_combo_nxt} / 9'(COMBO_STEP));
        w_mult_nxt = (w_mult_raw > 9'(MAX_MULT)) ? 3'(MAX_MULT) : w_mult_raw[2:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_credits  <= '0;
            r_combo    <= '0;
            r_mult     <= 3'd1;
            r_lives    <= 2'(LIVES);
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credits  <= w_credits_nxt;
            r_combo    <= w_combo_nxt;
            r_mult     <= w_mult_nxt;
            r_lives    <= w_lives_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign increment    = w_issue;
    assign score_resetn = (r_state != S_IDLE);
    assign combo        = r_combo;
    assign mult         = r_mult;
    assign lives        = r_lives;
    assign busy         = (r_credits != '0);
    assign overflow     = r_overflow;
    assign game_over    = (r_state == S_OVER);

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed bench: cycle table for the default build with an external score
// counter model, plus a narrow-credit build for saturation and combo limits.
module tb_score_event_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0, miss = 1'b0;
    logic [3:0] hit = 4'd0;
    logic       increment, score_resetn, busy, overflow, game_over;
    logic [7:0] combo;
    logic [2:0] mult;
    logic [1:0] lives;

    logic       start3 = 1'b0, miss3 = 1'b0;
    logic [3:0] hit3 = 4'd0;
    logic       increment3, score_resetn3, busy3, overflow3, game_over3;
    logic [7:0] combo3;
    logic [2:0] mult3;
    logic [1:0] lives3;

    int errors = 0;
    int checks = 0;
    int score_q = 0;

    score_event_scheduler u_dut (
        .clock(clock), .resetn(resetn), .start(start), .hit(hit), .miss(miss),
        .increment(increment), .score_resetn(score_resetn), .combo(combo),
        .mult(mult), .lives(lives), .busy(busy), .overflow(overflow),
        .game_over(game_over)
    );

    score_event_scheduler #(.PEND_W(3)) u_dut3 (
        .clock(clock), .resetn(resetn), .start(start3), .hit(hit3), .miss(miss3),
        .increment(increment3), .score_resetn(score_resetn3), .combo(combo3),
        .mult(mult3), .lives(lives3), .busy(busy3), .overflow(overflow3),
        .game_over(game_over3)
    );

    always #5 clock = ~clock;

    // External score counter: synchronous active-low clear, +1 per increment.
    always @(posedge clock) begin
        if (!score_resetn) score_q <= 0;
        else if (increment) score_q <= score_q + 1;
    end

    typedef struct {
        logic       st;
        logic [3:0] h;
        logic       m;
        logic       inc;
        logic       bsy;
        logic [7:0] cmb;
        logic [2:0] ml;
        logic [1:0] lv;
        logic       go;
        logic       srn;
        int         score;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic st, logic [3:0] h, logic m, logic inc, logic bsy,
                                logic [7:0] cmb, logic [2:0] ml, logic [1:0] lv,
                                logic go, logic srn, int score);
        vec_t v;
        v.st = st; v.h = h; v.m = m; v.inc = inc; v.bsy = bsy; v.cmb = cmb;
        v.ml = ml; v.lv = lv; v.go = go; v.srn = srn; v.score = score;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //            st h     m  inc bsy cmb ml lv go srn score
        tv.push_back(mk(1, 4'h0, 0, 0, 0, 0, 1, 3, 0, 1, 0));   // start -> PLAY
        tv.push_back(mk(0, 4'h1, 0, 1, 1, 1, 1, 3, 0, 1, 0));   // first hit
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 3, 0, 1, 1));
        tv.push_back(mk(0, 4'h2, 0, 1, 1, 2, 1, 3, 0, 1, 1));   // hits 2..8
        tv.push_back(mk(0, 4'h4, 0, 1, 1, 3, 1, 3, 0, 1, 2));
        tv.push_back(mk(0, 4'h8, 0, 1, 1, 4, 1, 3, 0, 1, 3));
        tv.push_back(mk(0, 4'h1, 0, 1, 1, 5, 1, 3, 0, 1, 4));
        tv.push_back(mk(0, 4'h2, 0, 1, 1, 6, 1, 3, 0, 1, 5));
        tv.push_back(mk(0, 4'h4, 0, 1, 1, 7, 1, 3, 0, 1, 6));
        tv.push_back(mk(0, 4'h8, 0, 1, 1, 8, 2, 3, 0, 1, 7));   // 8th hit -> mult 2
        tv.push_back(mk(0, 4'h1, 0, 1, 1, 9, 2, 3, 0, 1, 8));   // 9th hit worth 2
        tv.push_back(mk(0, 4'h0, 0, 1, 1, 9, 2, 3, 0, 1, 9));
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 9, 2, 3, 0, 1, 10));
        tv.push_back(mk(0, 4'h2, 1, 1, 1, 0, 1, 2, 0, 1, 10));  // miss+hit at old mult
        tv.push_back(mk(0, 4'h0, 0, 1, 1, 0, 1, 2, 0, 1, 11));
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 2, 0, 1, 12));
        tv.push_back(mk(0, 4'hF, 0, 1, 1, 4, 1, 2, 0, 1, 12));  // four lanes at once
        tv.push_back(mk(0, 4'h0, 0, 1, 1, 4, 1, 2, 0, 1, 13));
        tv.push_back(mk(0, 4'h0, 0, 1, 1, 4, 1, 2, 0, 1, 14));
        tv.push_back(mk(0, 4'h0, 0, 1, 1, 4, 1, 2, 0, 1, 15));
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 4, 1, 2, 0, 1, 16));
        tv.push_back(mk(0, 4'h7, 1, 1, 1, 0, 1, 1, 0, 1, 16));  // 3 credits pending
        tv.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0, 0, 1, 17));  // last life -> DRAIN
        tv.push_back(mk(0, 4'hF, 0, 1, 1, 0, 1, 0, 0, 1, 18));  // hit ignored in DRAIN
        tv.push_back(mk(0, 4'h0, 1, 0, 0, 0, 1, 0, 0, 1, 19));  // miss ignored, no wrap
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0, 1, 1, 19));  // OVER
        tv.push_back(mk(1, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 19));  // -> IDLE
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0));   // score cleared
        tv.push_back(mk(0, 4'hF, 1, 0, 0, 0, 1, 0, 0, 0, 0));   // IDLE ignores hit/miss
        tv.push_back(mk(1, 4'hF, 1, 0, 0, 0, 1, 3, 0, 1, 0));   // start cycle ignores hit/miss
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 3, 0, 1, 0));
        tv.push_back(mk(1, 4'h1, 0, 1, 1, 1, 1, 3, 0, 1, 0));   // start in PLAY ignored
        tv.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 3, 0, 1, 1));

        repeat (3) @(posedge clock);
        #1;
        chk("rst_inc", increment, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_go", game_over, 0);
        chk("rst_srn", score_resetn, 0);
        chk("rst_combo", combo, 0);
        chk("rst_mult", mult, 1);
        chk("rst_lives", lives, 3);
        resetn = 1'b1;
        step();
        chk("idle_srn", score_resetn, 0);

        for (int i = 0; i < tv.size(); i++) begin
            start = tv[i].st; hit = tv[i].h; miss = tv[i].m;
            step();
            chk($sformatf("v%0d_inc", i), increment, tv[i].inc);
            chk($sformatf("v%0d_busy", i), busy, tv[i].bsy);
            chk($sformatf("v%0d_combo", i), combo, tv[i].cmb);
            chk($sformatf("v%0d_mult", i), mult, tv[i].ml);
            chk($sformatf("v%0d_lives", i), lives, tv[i].lv);
            chk($sformatf("v%0d_go", i), game_over, tv[i].go);
            chk($sformatf("v%0d_srn", i), score_resetn, tv[i].srn);
            chk($sformatf("v%0d_score", i), score_q, tv[i].score);
        end
        start = 0; hit = 0; miss = 0;

        // Async reset while DRAIN still holds credits.
        hit = 4'hF; miss = 1; step();
        hit = 4'h0; step();
        step();
        miss = 0;
        chk("drain_busy", busy, 1);
        chk("drain_lives", lives, 0);
        chk("drain_srn", score_resetn, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_inc", increment, 0);
        chk("arst_busy", busy, 0);
        chk("arst_srn", score_resetn, 0);
        chk("arst_lives", lives, 3);
        @(negedge clock) resetn = 1'b1;
        step();
        step();
        chk("arst_score", score_q, 0);
        chk("arst_inc2", increment, 0);

        // Narrow credit counter: saturation, overflow stickiness, combo limits.
        start3 = 1; step(); start3 = 0;
        for (int k = 1; k <= 65; k++) begin
            hit3 = 4'hF;
            step();
            if (k == 2) begin
                chk("sat_k2_ovf", overflow3, 0);
                chk("sat_k2_mult", mult3, 2);
            end
            if (k == 3) chk("sat_k3_ovf", overflow3, 1);
            if (k == 6) chk("sat_k6_mult", mult3, 4);
            if (k == 63) chk("combo_252", combo3, 252);
            if (k == 64) chk("combo_255", combo3, 255);
            if (k == 65) begin
                chk("combo_hold", combo3, 255);
                chk("mult_ceiling", mult3, 4);
                chk("sat_busy", busy3, 1);
            end
        end
        hit3 = 0;
        miss3 = 1;
        repeat (3) step();
        miss3 = 0;
        chk("sat_lives0", lives3, 0);
        begin
            int n = 0;
            while (!game_over3 && n < 40) begin
                step();
                n++;
            end
        end
        chk("sat_drain_done", game_over3, 1);
        chk("sat_drain_busy", busy3, 0);
        chk("ovf_sticky_over", overflow3, 1);
        start3 = 1; step(); start3 = 0;
        chk("ovf_sticky_idle", overflow3, 1);
        chk("idle_srn3", score_resetn3, 0);
        start3 = 1; step(); start3 = 0;
        chk("ovf_cleared", overflow3, 0);
        chk("replay_lives", lives3, 3);
        chk("replay_inc", increment3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
